operand_triple_gather: RTL and testbench
========================================

OPERAND_TRIPLE_GATHER -- requirements
Module: operand_triple_gather

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of every operand.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-low (asserted when 0, sampled on rising clk only).
REQ-004 SHALL have port in_valid, input, 1: in_data/in_last are valid this cycle.
REQ-005 SHALL have port in_ready, output, 1: block accepts an operand this cycle.
REQ-006 SHALL have port in_data, input, WIDTH: one operand of the serial stream.
REQ-007 SHALL have port in_last, input, 1: operand closes its group early; missing slots are zero-padded.
REQ-008 SHALL have port out_valid, output, 1: out0/out1/out2/out_count hold a complete triple.
REQ-009 SHALL have port out_ready, input, 1: downstream 3-input adder stage consumes the triple.
REQ-010 SHALL have ports out0, out1, out2, output, WIDTH each: triple in arrival order, feeding the adder's in0/in1/in2.
REQ-011 SHALL have port out_count, output, 2: number of real operands in the triple (1..3).

Function
REQ-012 Input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; output transfer on a cycle with out_valid=1 and out_ready=1.
REQ-013 Gather stage SHALL hold slot index 0..2 and three slot registers; each input transfer writes in_data to the current slot.
REQ-014 A group SHALL close on the transfer into slot 2, or on any transfer with in_last=1; unfilled slots SHALL read 0; out_count = filled slots.
REQ-015 FSM states SHALL be GATHER (accepting, in_ready=1) and HOLD (closed group waiting, in_ready=0).
REQ-016 GATHER, group closes, and output register empty or draining this cycle: triple SHALL load into the output register on the same edge; slot index returns to 0; stay in GATHER.
REQ-017 GATHER, group closes, output register full and not draining: SHALL go to HOLD keeping the triple in the gather registers.
REQ-018 HOLD: on the cycle the output transfer occurs, the held triple SHALL load into the output register on that edge and the FSM returns to GATHER (no bubble).
REQ-019 Latency: closing transfer in cycle N SHALL give out_valid=1 in cycle N+1 if not blocked.
REQ-020 out_valid, out0..out2 and out_count SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 Sustained throughput SHALL be one operand per cycle with out_ready held 1.
REQ-022 in_valid=0 SHALL not advance the slot index; partial groups persist indefinitely.
REQ-023 in_ready SHALL be a function of registered state only (no combinational path from out_ready).
REQ-024 Operand data SHALL be passed unmodified; no arithmetic in this block.

Reset
REQ-025 While rst=0 at a rising edge: FSM to GATHER, slot index 0, out_valid 0, out0..out2 0, out_count 0, slot registers 0.
REQ-026 in_ready SHALL be 0 during reset cycles and 1 from the first cycle after rst returns to 1.
REQ-027 Reset mid-group or mid-stall SHALL discard all partial and pending data; no triple emitted afterwards from pre-reset operands.

Structure
REQ-028 FSM state enum (GATHER, HOLD) and the out_count width constant SHALL live in shared package adder_3input_pkg.
REQ-029 SHALL be a single module, no sub-modules; registered output register drives the adder directly.

Verification
REQ-030 Stream 1,2,3 back-to-back, out_ready=1 -> one triple (1,2,3), out_count=3, out_valid one cycle after the 3.
REQ-031 Stream 5, then 7 with in_last=1 -> triple (5,7,0), out_count=2; then 9 with in_last=1 -> (9,0,0), out_count=1.
REQ-032 out_ready=0, stream 1..6 -> (1,2,3) held stable, FSM HOLD, in_ready=0 after 6; raise out_ready -> (1,2,3) then (4,5,6) on consecutive cycles.
REQ-033 Continuous 12 operands 0xFFFF down, out_ready=1 -> 4 triples, in_ready never 0, values unmodified at WIDTH=16.
REQ-034 Send 1,2 then rst=0 for one cycle, then 3,4,5 -> only triple (3,4,5); all outputs 0 during reset.
REQ-035 Random in_valid/out_ready throttling, 1000 operands vs. scoreboard -> every triple matches, no loss or duplication.

Source files
------------

// File: rtl/adder_3input_pkg.sv
// Shared definitions for the operand gather stage that feeds the 3-input adder.
//   gather_state_e : FSM state encoding for the gather controller
//   COUNT_W        : width of the operand-count field handed to the adder
package adder_3input_pkg;

  typedef enum logic {
    GATHER = 1'b0,
    HOLD   = 1'b1
  } gather_state_e;

  localparam int COUNT_W = 2;

endpackage

// File: rtl/operand_triple_gather.sv
// Collects a serial operand stream into triples for a downstream 3-input adder.
// A group closes after three operands or on an operand flagged in_last; missing
// slots read as zero. The registered output triple drives the adder directly.
//
// State table
//   state  | meaning
//   GATHER | accepting operands into the slot registers
//   HOLD   | closed group parked in the slot registers, waiting for the output
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-low reset
//   in_valid   : in_data / in_last valid this cycle
//   in_ready   : block accepts an operand this cycle
//   in_data    : one operand of the stream
//   in_last    : operand closes its group early
//   out_valid  : out0..out2 / out_count hold a complete triple
//   out_ready  : adder consumes the triple
//   out0..out2 : triple in arrival order
//   out_count  : number of real operands in the triple (1..3)
module operand_triple_gather
  import adder_3input_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out0,
  output logic [WIDTH-1:0]   out1,
  output logic [WIDTH-1:0]   out2,
  output logic [COUNT_W-1:0] out_count
);

  gather_state_e      state, state_next;
  // In GATHER this is the next slot to fill; in HOLD it is the held operand count.
  logic [COUNT_W-1:0] slot_idx;
  logic [WIDTH-1:0]   slot0, slot1, slot2;
  logic [WIDTH-1:0]   n0, n1, n2;
  logic               take, closes, out_free, load_direct, load_held;

  assign take        = in_valid & in_ready;
  assign closes      = take & (in_last | (slot_idx == COUNT_W'(2)));
  assign out_free    = ~out_valid | out_ready;
  assign load_direct = (state == GATHER) & closes & out_free;
  // out_valid is always set while in HOLD, so out_ready alone means a transfer.
  assign load_held   = (state == HOLD) & out_ready;

  // Slot contents including this cycle's operand; slots are cleared after
  // every hand-off, so unfilled slots already read zero.
  assign n0 = (take && slot_idx == COUNT_W'(0)) ? in_data : slot0;
  assign n1 = (take && slot_idx == COUNT_W'(1)) ? in_data : slot1;
  assign n2 = (take && slot_idx == COUNT_W'(2)) ? in_data : slot2;

  always_ff @(posedge clk) begin
    if (!rst) state <= GATHER;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      GATHER: if (closes && !out_free) state_next = HOLD;
      HOLD:   if (out_ready)           state_next = GATHER;
      default:                         state_next = GATHER;
    endcase
  end

  // Gated with rst so the port reads 0 throughout reset cycles.
  always_comb begin
    in_ready = rst && (state == GATHER);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_idx  <= '0;
      slot0     <= '0;
      slot1     <= '0;
      slot2     <= '0;
      out_valid <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
      out_count <= '0;
    end else begin
      if (load_direct) begin
        out0      <= n0;
        out1      <= n1;
        out2      <= n2;
        out_count <= slot_idx + COUNT_W'(1);
        slot0     <= '0;
        slot1     <= '0;
        slot2     <= '0;
        slot_idx  <= '0;
      end else if (load_held) begin
        out0      <= slot0;
        out1      <= slot1;
        out2      <= slot2;
        out_count <= slot_idx;
        slot0     <= '0;
        slot1     <= '0;
        slot2     <= '0;
        slot_idx  <= '0;
      end else if (take) begin
        // On a blocked close this leaves the count (1..3) in slot_idx for HOLD.
        slot0    <= n0;
        slot1    <= n1;
        slot2    <= n2;
        slot_idx <= slot_idx + COUNT_W'(1);
      end

      if (load_direct || load_held) out_valid <= 1'b1;
      else if (out_ready)           out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_triple_gather.sv
module tb_operand_triple_gather;
  import adder_3input_pkg::*;

  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out0, out1, out2;
  logic [COUNT_W-1:0] out_count;

  int n_vec = 0;
  int n_err = 0;
  bit rnd_mode = 0;

  operand_triple_gather #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .out2(out2), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic [WIDTH-1:0] c, input logic [1:0] cnt);
    return {14'd0, cnt, c, b, a};
  endfunction

  // Reference model: operands accepted so far in the open group, and the
  // triples that must come out, in order.
  logic [WIDTH-1:0] grp[$];
  logic [63:0]      exp_q[$];
  bit               prev_stall = 0;
  logic [64:0]      prev_obs;

  always @(posedge clk) begin
    if (!rst) begin
      grp.delete();
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall)
        check("stall_stable", {1'b0, out_valid, pack(out0, out1, out2, out_count)}, prev_obs);
      if (in_valid && in_ready) begin
        grp.push_back(in_data);
        if (in_last || grp.size() == 3) begin
          logic [WIDTH-1:0] w [3];
          for (int i = 0; i < 3; i++) w[i] = (i < grp.size()) ? grp[i] : '0;
          exp_q.push_back(pack(w[0], w[1], w[2], 2'(grp.size())));
          grp.delete();
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_triple", pack(out0, out1, out2, out_count), 64'hDEAD);
        else                   check("triple", pack(out0, out1, out2, out_count), exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_obs   = {1'b0, out_valid, pack(out0, out1, out2, out_count)};
    end
  end

  always @(negedge clk) begin
    if (rnd_mode) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    bit got = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int k = 0; k < 300 && !got; k++) begin
      got = in_ready;
      @(negedge clk);
    end
    if (!got) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check(tag, {in_ready, out_valid, pack(out0, out1, out2, out_count)}, 64'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset_state");
    rst = 1'b1;
    #1 check("ready_after_reset", in_ready, 1);
    @(negedge clk);

    // three back-to-back operands, output one cycle after the third
    out_ready = 1'b1;
    send(1, 0); send(2, 0); send(3, 0);
    check("t030_latency", {out_valid, pack(out0, out1, out2, out_count)}, {1'b1, pack(1, 2, 3, 3)});
    idle(2);

    // early close with zero padding
    send(5, 0); send(7, 1);
    check("t031_pair", {out_valid, pack(out0, out1, out2, out_count)}, {1'b1, pack(5, 7, 0, 2)});
    send(9, 1);
    check("t031_single", {out_valid, pack(out0, out1, out2, out_count)}, {1'b1, pack(9, 0, 0, 1)});
    idle(2);

    // blocked output: second triple parks in HOLD
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(16'(i), 0);
    in_valid = 1'b0;
    check("t032_ready_low", in_ready, 0);
    check("t032_state_hold", dut.state, HOLD);
    check("t032_held_out", {out_valid, pack(out0, out1, out2, out_count)}, {1'b1, pack(1, 2, 3, 3)});
    idle(3);
    out_ready = 1'b1;
    @(negedge clk);
    check("t032_second", {out_valid, pack(out0, out1, out2, out_count)}, {1'b1, pack(4, 5, 6, 3)});
    check("t032_ready_back", in_ready, 1);
    idle(2);

    // full-rate stream, in_ready must never drop
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = 16'hFFFF - 16'(i); in_last = 1'b0;
      check("t033_ready", in_ready, 1);
      @(negedge clk);
    end
    idle(3);

    // reset mid-group discards the partial operands
    send(1, 0); send(2, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("t034_in_reset");
    check("t034_slot_cleared", dut.slot0, 0);
    rst = 1'b1;
    #1 check("t034_ready_release", in_ready, 1);
    @(negedge clk);
    send(3, 0); send(4, 0); send(5, 0);
    check("t034_after", {out_valid, pack(out0, out1, out2, out_count)}, {1'b1, pack(3, 4, 5, 3)});
    idle(2);

    // reset during a stall discards held data too
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(16'(20 + i), 0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("stall_reset");
    rst = 1'b1;
    out_ready = 1'b1;
    idle(4);
    check("stall_reset_quiet", out_valid, 0);

    // random throttling on both sides
    rnd_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      idle($urandom_range(0, 2));
      send(16'($urandom), (i == 999) || ($urandom_range(0, 3) == 0));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    rnd_mode = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 200 && (exp_q.size() != 0 || out_valid); k++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 0);
    check("drain_idle", out_valid, 0);
    check("open_group_empty", 64'(grp.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
